hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and control-flow controller that drives the stall/flush controls of the ID/EXE pipeline register and the CE inputs of the PC and IF/ID registers. It compares ID-stage source registers against the destination registers in EXE (and in MEM) to detect RAW hazards. It resolves branches in EXE against the prediction carried down the pipe and issues the redirect. It also owns the branch history table (BHT) that supplies the `prediction` bit consumed in ID.

## Interface
- BHT_IDX_W, 4, BHT index width; the table has 2^BHT_IDX_W 2-bit counters indexed by PC[BHT_IDX_W+1:2]
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_PC  in  32  PC of the instruction in ID (BHT lookup)
- id_rs1, id_rs2  in  5  ID source register numbers
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2
- id_branch  in  2  ID branch class: 00 none, 01 conditional, 10 jump, 11 reserved (treated as 00)
- ex_PC  in  32  PC of the instruction in EXE
- ex_written_reg  in  5  EXE destination register
- ex_reg_write  in  1  EXE writes the register file
- ex_data_to_reg  in  2  EXE writeback select; 2'b01 = load
- ex_branch  in  2  EXE branch class
- ex_prediction  in  1  prediction made in ID for the EXE instruction
- ex_taken  in  1  actual outcome from the ALU (valid when ex_branch != 00)
- ex_fallback_PC  in  32  the PC not chosen at prediction time
- mem_written_reg  in  5  MEM destination register
- mem_reg_write  in  1  MEM writes the register file
- prediction  out  1  prediction for the ID instruction
- pc_ce  out  1  PC register enable
- if_id_ce  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_exe_dstall  out  1  ID/EXE loads a bubble (data hazard)
- id_exe_cstall  out  1  ID/EXE loads a bubble (control hazard)
- redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  32  corrected fetch address
- branch_cnt  out  16  conditional branches resolved
- mispredict_cnt  out  16  redirects issued

## Operation
- Mispredict: ex_branch==01 && ex_taken!=ex_prediction, or ex_branch==10 && ex_prediction==0.
- Mispredict has priority over every hazard: redirect=1, redirect_pc=ex_fallback_PC, pc_ce=1, if_id_flush=1, id_exe_cstall=1, id_exe_dstall=0.
- RAW hazard, without mispredict:
  - id_exe_dstall=1, pc_ce=0, if_id_ce=0.
  - PC and IF/ID hold; one bubble enters EXE.
- A source matches only when its use bit is set and the register is nonzero; x0 never stalls.
- Otherwise: pc_ce=1, if_id_ce=1, all other control outputs 0, redirect_pc=ex_fallback_PC (don't care).
- prediction:
  - id_branch==10 → 1.
  - id_branch==01 → MSB of BHT[id_PC idx].
  - Otherwise → 0.
- BHT: 2-bit saturating counters, updated at the clock edge when ex_branch==01, at index ex_PC.
  - Taken: +1, saturating at 3.
  - Not taken: −1, saturating at 0.
- A same-cycle lookup and update of the same index returns the pre-update value; there is no bypass.
- branch_cnt increments on every ex_branch==01 edge. mispredict_cnt increments on every mispredict edge. Both wrap 16'hFFFF→0.

## Timing
- All control outputs and prediction are combinational from the current inputs and BHT state: zero-cycle latency.
- The BHT and both counters update on posedge clk.
- A load-use hazard yields exactly one dstall cycle. The next cycle the load has moved to MEM and forwarding covers it.
- rst asserted (asynchronously):
  - All BHT entries → 2'b01 (weakly not-taken).
  - branch_cnt=0, mispredict_cnt=0.
  - Combinational outputs follow their inputs; the downstream registers are themselves reset.
- Reset mid-operation discards all history; the first post-reset conditional branch predicts not-taken.
- Mispredict and load-use in the same cycle: cstall only, no dstall. The ID instruction is wrong-path.

## Configuration
- HAZARD_FWD_EN
  - Defined: the pipeline has EXE/MEM forwarding. A RAW hazard is only a load-use hazard: ex_reg_write && ex_data_to_reg==01 && ex_written_reg matches an ID source.
  - Undefined: no forwarding.
    - Any ID source matching ex_written_reg (ex_reg_write=1) or mem_written_reg (mem_reg_write=1) stalls.
    - A producer in EXE gives 2 dstall cycles; a producer in MEM gives 1.
  - mem_* inputs are ignored when HAZARD_FWD_EN is defined.

## Test plan
- Reset: after rst, id_branch=01 for any id_PC → prediction=0. branch_cnt=0, mispredict_cnt=0. pc_ce=1, if_id_ce=1.
- Load-use (FWD_EN), with ex: reg_write=1, data_to_reg=01, written_reg=5; id: rs1=5, uses_rs1=1.
  - Response: dstall=1, pc_ce=0, if_id_ce=0 for exactly 1 cycle.
  - Same case with id_rs1=0 and ex_written_reg=0 → no stall.
- No-FWD, with ex ALU op writing x7 and ID reading rs2=7 → dstall for 2 consecutive cycles as x7 moves EXE→MEM, then released.
- Mispredict: ex_branch=01, ex_prediction=0, ex_taken=1, ex_fallback_PC=32'h0000_0040.
  - Response: redirect=1, redirect_pc=32'h40, if_id_flush=1, cstall=1, dstall=0 (even with a simultaneous load-use match). mispredict_cnt 0→1.
- BHT training: 3 taken resolutions at ex_PC=32'h10 → BHT[4] goes 01→10→11→11. Prediction for id_PC=32'h10 becomes 1 after the first update. A same-cycle lookup during the first update returns 0.
- Counter wrap: preload by 65535 resolved branches → branch_cnt=16'hFFFF. The next one gives 16'h0000.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, branch resolution/redirect and a 2-bit BHT.
// Optional feature macro: HAZARD_FWD_EN (EXE/MEM forwarding present, only load-use stalls).
module hazard_ctrl #(
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_PC,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [1:0]  id_branch,
  input  logic [31:0] ex_PC,
  input  logic [4:0]  ex_written_reg,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_data_to_reg,
  input  logic [1:0]  ex_branch,
  input  logic        ex_prediction,
  input  logic        ex_taken,
  input  logic [31:0] ex_fallback_PC,
  input  logic [4:0]  mem_written_reg,
  input  logic        mem_reg_write,
  output logic        prediction,
  output logic        pc_ce,
  output logic        if_id_ce,
  output logic        if_id_flush,
  output logic        id_exe_dstall,
  output logic        id_exe_cstall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt
);

  localparam int unsigned BHT_DEPTH = 32'(1) << BHT_IDX_W;
  localparam logic [1:0]  BR_COND   = 2'b01;
  localparam logic [1:0]  BR_JUMP   = 2'b10;
  localparam logic [1:0]  WB_LOAD   = 2'b01;

  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d;
  logic [15:0]          branch_cnt_q;
  logic [15:0]          mispredict_cnt_q;
  logic [BHT_IDX_W-1:0] id_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 mispredict;
  logic                 ex_cond;
  logic                 rs1_ex_hit;
  logic                 rs2_ex_hit;
  logic                 raw_hazard;

  assign id_idx  = id_PC[BHT_IDX_W+1:2];
  assign ex_idx  = ex_PC[BHT_IDX_W+1:2];
  assign ex_cond = (ex_branch == BR_COND);

  // PC bits outside the BHT index are not needed here.
  logic unused_pc;
  assign unused_pc = ^{id_PC[31:BHT_IDX_W+2], id_PC[1:0], ex_PC[31:BHT_IDX_W+2], ex_PC[1:0]};

  // ID source matches against the EXE destination; x0 and unused sources never match.
  assign rs1_ex_hit = id_uses_rs1 && (id_rs1 != 5'd0) && (id_rs1 == ex_written_reg);
  assign rs2_ex_hit = id_uses_rs2 && (id_rs2 != 5'd0) && (id_rs2 == ex_written_reg);

`ifdef HAZARD_FWD_EN
  // With forwarding only a load in EXE feeding ID must wait one cycle.
  logic unused_mem;
  assign unused_mem = ^{mem_written_reg, mem_reg_write};
  assign raw_hazard = ex_reg_write && (ex_data_to_reg == WB_LOAD) && (rs1_ex_hit || rs2_ex_hit);
`else
  // Without forwarding any producer still in EXE or MEM blocks the ID reader.
  logic rs1_mem_hit;
  logic rs2_mem_hit;
  logic unused_wb;
  assign unused_wb   = ^{ex_data_to_reg, WB_LOAD};
  assign rs1_mem_hit = id_uses_rs1 && (id_rs1 != 5'd0) && (id_rs1 == mem_written_reg);
  assign rs2_mem_hit = id_uses_rs2 && (id_rs2 != 5'd0) && (id_rs2 == mem_written_reg);
  assign raw_hazard  = (ex_reg_write && (rs1_ex_hit || rs2_ex_hit)) ||
                       (mem_reg_write && (rs1_mem_hit || rs2_mem_hit));
`endif

  // Branch resolution against the prediction carried down from ID.
  assign mispredict = (ex_cond && (ex_taken != ex_prediction)) ||
                      ((ex_branch == BR_JUMP) && !ex_prediction);

  // Pipeline control: a redirect overrides any data hazard because ID is wrong-path.
  always_comb begin
    pc_ce         = 1'b1;
    if_id_ce      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_dstall = 1'b0;
    id_exe_cstall = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = ex_fallback_PC;
    if (mispredict) begin
      redirect      = 1'b1;
      if_id_flush   = 1'b1;
      id_exe_cstall = 1'b1;
    end else if (raw_hazard) begin
      id_exe_dstall = 1'b1;
      pc_ce         = 1'b0;
      if_id_ce      = 1'b0;
    end
  end

  // ID-stage prediction: jumps always taken, conditionals from the counter MSB.
  always_comb begin
    prediction = 1'b0;
    case (id_branch)
      BR_JUMP: prediction = 1'b1;
      BR_COND: prediction = bht_q[id_idx][1];
      default: prediction = 1'b0;
    endcase
  end

  // Saturating counter step for the entry being resolved in EXE.
  always_comb begin
    bht_d = bht_q[ex_idx];
    if (ex_taken) begin
      if (bht_q[ex_idx] != 2'b11) bht_d = bht_q[ex_idx] + 2'd1;
    end else begin
      if (bht_q[ex_idx] != 2'b00) bht_d = bht_q[ex_idx] - 2'd1;
    end
  end

  // BHT training and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= 2'b01;
      branch_cnt_q     <= 16'd0;
      mispredict_cnt_q <= 16'd0;
    end else begin
      if (ex_cond) begin
        bht_q[ex_idx] <= bht_d;
        branch_cnt_q  <= branch_cnt_q + 16'd1;
      end
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected control vectors are queued and then checked.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_PC;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_uses_rs1, id_uses_rs2;
  logic [1:0]  id_branch;
  logic [31:0] ex_PC;
  logic [4:0]  ex_written_reg;
  logic        ex_reg_write;
  logic [1:0]  ex_data_to_reg;
  logic [1:0]  ex_branch;
  logic        ex_prediction;
  logic        ex_taken;
  logic [31:0] ex_fallback_PC;
  logic [4:0]  mem_written_reg;
  logic        mem_reg_write;
  logic        prediction, pc_ce, if_id_ce, if_id_flush;
  logic        id_exe_dstall, id_exe_cstall, redirect;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispredict_cnt;

  hazard_ctrl #(.BHT_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .id_PC(id_PC), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_branch(id_branch),
    .ex_PC(ex_PC), .ex_written_reg(ex_written_reg), .ex_reg_write(ex_reg_write),
    .ex_data_to_reg(ex_data_to_reg), .ex_branch(ex_branch), .ex_prediction(ex_prediction),
    .ex_taken(ex_taken), .ex_fallback_PC(ex_fallback_PC), .mem_written_reg(mem_written_reg),
    .mem_reg_write(mem_reg_write), .prediction(prediction), .pc_ce(pc_ce), .if_id_ce(if_id_ce),
    .if_id_flush(if_id_flush), .id_exe_dstall(id_exe_dstall), .id_exe_cstall(id_exe_cstall),
    .redirect(redirect), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Vector layout: {prediction, pc_ce, if_id_ce, if_id_flush, dstall, cstall, redirect}
  localparam logic [6:0] NORM  = 7'b0110000;
  localparam logic [6:0] PRED  = 7'b1000000;
  localparam logic [6:0] STALL = 7'b0000100;
  localparam logic [6:0] MISP  = 7'b0111011;
  localparam logic [6:0] ALL   = 7'b1111111;
  localparam logic [6:0] MMASK = 7'b1101111;  // if_id_ce is free during a redirect

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [6:0]  mask;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_b = 16'd0;
  logic [15:0] exp_m = 16'd0;

  task automatic expect_ctl(input string tag, input logic [6:0] ctl, input logic [6:0] mask,
                            input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.mask = mask; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic compare_ctl();
    exp_t       e;
    logic [6:0] obs;
    #1;
    e   = exp_q.pop_front();
    obs = {prediction, pc_ce, if_id_ce, if_id_flush, id_exe_dstall, id_exe_cstall, redirect};
    checks++;
    assert ((obs & e.mask) === (e.ctl & e.mask))
      else begin
        failures++;
        $error("FAIL %s ctl got=%b want=%b mask=%b", e.tag, obs, e.ctl, e.mask);
      end
    if (e.ctl[0]) begin
      checks++;
      assert (redirect_pc === e.pc)
        else begin
          failures++;
          $error("FAIL %s redirect_pc got=%h want=%h", e.tag, redirect_pc, e.pc);
        end
    end
  endtask

  task automatic step(input string tag, input logic [6:0] ctl, input logic [6:0] mask,
                      input logic [31:0] pc);
    expect_ctl(tag, ctl, mask, pc);
    compare_ctl();
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want)
      else begin
        failures++;
        $error("FAIL %s got=%h want=%h", tag, got, want);
      end
  endtask

  // Advance one clock, updating the counter model from the inputs seen at the edge.
  task automatic tick();
    if (ex_branch == 2'b01) exp_b++;
    if ((ex_branch == 2'b01 && ex_taken != ex_prediction) || (ex_branch == 2'b10 && !ex_prediction))
      exp_m++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_PC = 32'h0; ex_written_reg = 5'd0; ex_reg_write = 1'b0; ex_data_to_reg = 2'b00;
    ex_branch = 2'b00; ex_prediction = 1'b0; ex_taken = 1'b0; ex_fallback_PC = 32'h0;
    mem_written_reg = 5'd0; mem_reg_write = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id_PC = 32'h10; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_branch = 2'b01;
    clear_ex();
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    step("reset_pred", NORM, ALL, 32'h0);
    check_cnt("reset_bcnt", branch_cnt, 16'd0);
    check_cnt("reset_mcnt", mispredict_cnt, 16'd0);
    id_branch = 2'b10;
    step("jump_pred", NORM | PRED, ALL, 32'h0);
    id_branch = 2'b11;
    step("reserved_pred", NORM, ALL, 32'h0);
    id_branch = 2'b00;

    // x0 never stalls
    ex_reg_write = 1'b1; ex_data_to_reg = 2'b01; ex_written_reg = 5'd0;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    step("x0_nostall", NORM, ALL, 32'h0);
    tick();

    // Load-use on rs1 = x5
    ex_written_reg = 5'd5; id_rs1 = 5'd5;
    step("loaduse_c1", STALL, ALL, 32'h0);
    tick();
    ex_reg_write = 1'b0; ex_data_to_reg = 2'b00; ex_written_reg = 5'd0;
    mem_reg_write = 1'b1; mem_written_reg = 5'd5;
`ifdef HAZARD_FWD_EN
    step("loaduse_c2", NORM, ALL, 32'h0);
`else
    step("loaduse_c2", STALL, ALL, 32'h0);
`endif
    tick();
    clear_ex();
    ex_reg_write = 1'b1; ex_data_to_reg = 2'b01; ex_written_reg = 5'd5; id_uses_rs1 = 1'b0;
    step("unused_src", NORM, ALL, 32'h0);
    tick();

    // ALU producer of x7 read on rs2
    clear_ex();
    id_rs1 = 5'd0; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    ex_reg_write = 1'b1; ex_data_to_reg = 2'b00; ex_written_reg = 5'd7;
`ifdef HAZARD_FWD_EN
    step("alu_ex", NORM, ALL, 32'h0);
`else
    step("alu_ex", STALL, ALL, 32'h0);
`endif
    tick();
    clear_ex();
    mem_reg_write = 1'b1; mem_written_reg = 5'd7;
`ifdef HAZARD_FWD_EN
    step("alu_mem", NORM, ALL, 32'h0);
`else
    step("alu_mem", STALL, ALL, 32'h0);
`endif
    tick();
    clear_ex();
    step("alu_done", NORM, ALL, 32'h0);
    tick();
    id_rs2 = 5'd0; id_uses_rs2 = 1'b0;

    // Conditional mispredict alongside a load-use match
    ex_branch = 2'b01; ex_prediction = 1'b0; ex_taken = 1'b1; ex_fallback_PC = 32'h0000_0040;
    ex_PC = 32'h80; ex_reg_write = 1'b1; ex_data_to_reg = 2'b01; ex_written_reg = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step("misp_cond", MISP, MMASK, 32'h0000_0040);
    tick();
    check_cnt("misp_mcnt", mispredict_cnt, exp_m);
    check_cnt("misp_bcnt", branch_cnt, exp_b);

    // Jump predicted not-taken is a mispredict; predicted taken is fine
    clear_ex();
    id_rs1 = 5'd0; id_uses_rs1 = 1'b0;
    ex_branch = 2'b10; ex_prediction = 1'b0; ex_fallback_PC = 32'h0000_1234;
    step("misp_jump", MISP, MMASK, 32'h0000_1234);
    tick();
    check_cnt("jump_mcnt", mispredict_cnt, exp_m);
    check_cnt("jump_bcnt", branch_cnt, exp_b);
    ex_prediction = 1'b1;
    step("jump_ok", NORM, ALL, 32'h0);

    // BHT training at index 4
    clear_ex();
    id_branch = 2'b01; id_PC = 32'h10;
    ex_branch = 2'b01; ex_PC = 32'h10; ex_taken = 1'b1; ex_prediction = 1'b1;
    step("bht_same_cycle", NORM, ALL, 32'h0);
    tick();
    step("bht_after1", NORM | PRED, ALL, 32'h0);
    tick();
    step("bht_after2", NORM | PRED, ALL, 32'h0);
    tick();
    ex_branch = 2'b00;
    step("bht_after3", NORM | PRED, ALL, 32'h0);
    ex_branch = 2'b01; ex_taken = 1'b0; ex_prediction = 1'b0;
    tick();
    ex_branch = 2'b00;
    step("bht_nt1", NORM | PRED, ALL, 32'h0);
    ex_branch = 2'b01;
    tick();
    ex_branch = 2'b00;
    step("bht_nt2", NORM, ALL, 32'h0);

    // Mid-operation reset discards history
    ex_branch = 2'b01; ex_taken = 1'b1; ex_prediction = 1'b1;
    tick();
    ex_branch = 2'b00;
    step("bht_retrain", NORM | PRED, ALL, 32'h0);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    exp_b = 16'd0; exp_m = 16'd0;
    step("rst_pred", NORM, ALL, 32'h0);
    check_cnt("rst_bcnt", branch_cnt, 16'd0);
    check_cnt("rst_mcnt", mispredict_cnt, 16'd0);
    @(negedge clk);

    // Counter wrap with correctly predicted branches
    ex_branch = 2'b01; ex_taken = 1'b0; ex_prediction = 1'b0; ex_PC = 32'h20;
    while (exp_b != 16'hFFFF) tick();
    #1;
    check_cnt("bcnt_ffff", branch_cnt, 16'hFFFF);
    tick();
    #1;
    check_cnt("bcnt_wrap", branch_cnt, 16'h0000);
    check_cnt("mcnt_after_wrap", mispredict_cnt, exp_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
